// File: rtl/pwm_multichannel_if.sv
// pwm_multichannel_if: width-write handshake from the modulator front end into the PWM block.
interface pwm_multichannel_if #(parameter int W = 11);
  logic wr_valid;
  logic wr_ready;
  logic [3:0] wr_channel;
  logic [W-1:0] wr_width;
  modport master (output wr_valid, wr_channel, wr_width, input wr_ready);
  modport slave (input wr_valid, wr_channel, wr_width, output wr_ready);
endinterface

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: shared single/dual-slope counter driving CHANNELS PWM comparators with boundary-applied widths.
// Define PWM_DITHER_EN for fractional widths dithered by per-channel accumulators.
module pwm_multichannel #(
  parameter int BITS = 11,
  parameter int CHANNELS = 4,
  parameter int FRAC_BITS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic [BITS-1:0] i_cfg_compare_max,
  input  logic i_cfg_dual_slope,
  pwm_multichannel_if.slave wr,
  output logic [CHANNELS-1:0] o_pending,
  output logic o_period_end,
  output logic [CHANNELS-1:0] o_pwm_out
);
`ifdef PWM_DITHER_EN
  localparam int W = BITS + FRAC_BITS;
`else
  localparam int W = BITS + 0 * FRAC_BITS;
`endif
  typedef enum logic {UP, DOWN} dir_t;
  dir_t r_dir, w_dir_nxt;
  logic [BITS-1:0] r_cnt, w_cnt_nxt, r_max;
  logic r_dual, w_end, w_dn;
  logic [W-1:0] r_shadow [CHANNELS];
  logic [W-1:0] r_active [CHANNELS];
  logic [W-1:0] w_next [CHANNELS];
  logic [BITS-1:0] r_width [CHANNELS];
  logic [BITS-1:0] w_eff [CHANNELS];
  logic [CHANNELS-1:0] r_pending, r_pwm, w_accept;
  logic [15:0] w_pend16;
`ifdef PWM_DITHER_EN
  logic [FRAC_BITS-1:0] r_acc [CHANNELS];
  logic [FRAC_BITS:0] w_sum [CHANNELS];
`endif
  // zero padding makes out-of-range channels always ready
  assign w_pend16 = 16'(r_pending);
  assign wr.wr_ready = !w_pend16[wr.wr_channel];
  assign w_accept = (wr.wr_valid && wr.wr_ready) ? CHANNELS'(16'd1 << wr.wr_channel) : '0;
  assign o_pending = r_pending;
  assign o_period_end = w_end;
  assign o_pwm_out = r_pwm;
  always_comb begin
    w_end = (r_max == '0) || (r_dual ? (r_max == BITS'(1) ? r_cnt == BITS'(1) : (r_dir == DOWN && r_cnt == BITS'(1))) : r_cnt == r_max);
    w_dn = r_dual && (r_dir == DOWN || r_cnt == r_max);
    w_cnt_nxt = w_end ? '0 : w_dn ? r_cnt - BITS'(1) : r_cnt + BITS'(1);
    w_dir_nxt = w_end ? UP : w_dn ? DOWN : r_dir;
  end
  always_comb
    for (int i = 0; i < CHANNELS; i++) begin
      w_next[i] = r_pending[i] ? r_shadow[i] : r_active[i];
`ifdef PWM_DITHER_EN
      w_sum[i] = {1'b0, r_acc[i]} + {1'b0, w_next[i][FRAC_BITS-1:0]};
      w_eff[i] = w_next[i][W-1:FRAC_BITS] + BITS'(w_sum[i][FRAC_BITS] && !(&w_next[i][W-1:FRAC_BITS]));
`else
      w_eff[i] = w_next[i];
`endif
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_dir <= UP;
      r_max <= '1;
      r_dual <= 1'b0;
      r_pending <= '0;
      r_pwm <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
        r_width[i] <= '0;
`ifdef PWM_DITHER_EN
        r_acc[i] <= '0;
`endif
      end
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
      r_pending <= (w_end ? '0 : r_pending) | w_accept;
      if (w_end) begin
        r_max <= i_cfg_compare_max;
        r_dual <= i_cfg_dual_slope;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_accept[i]) r_shadow[i] <= wr.wr_width;
        if (w_end) begin
          r_active[i] <= w_next[i];
          r_width[i] <= w_eff[i];
`ifdef PWM_DITHER_EN
          r_acc[i] <= w_sum[i][FRAC_BITS-1:0];
`endif
        end
        r_pwm[i] <= r_cnt < r_width[i];
      end
    end
endmodule
